// File: rtl/ms_count_ctrl.sv
// Run/pause/lap/clear sequencer for the millisecond counter: divides CLK to a
// 1 ms count enable, issues digit clears and controls the display latch.
module ms_count_ctrl #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int TICK_HZ = 1000,
  parameter int WRAP    = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic start_stop,
  input  logic clear,
  input  logic lap,
  input  logic cnt_tc,
  output logic cnt_en,
  output logic cnt_clr,
  output logic disp_latch_en,
  output logic running,
  output logic ovf
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int PSC_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_LAP,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [PSC_W-1:0] psc, psc_nx;
  logic             ss_p0, clr_p0, lap_p0;
  logic             ev_ss, ev_clr, ev_lap;
  logic             counting, tick;
  logic             en_nx, clr_nx, ovf_nx;

  // History regs reset to 1 so a button held through reset release is not an event
  assign ev_ss    = start_stop & ~ss_p0;
  assign ev_clr   = clear & ~clr_p0;
  assign ev_lap   = lap & ~lap_p0;
  assign counting = (state == S_RUN) || (state == S_LAP);
  assign tick     = counting && (psc == PSC_MAX);

  always_comb begin
    state_nx = state;
    psc_nx   = psc;
    en_nx    = 1'b0;
    clr_nx   = 1'b0;
    ovf_nx   = ovf;

    if (counting) begin
      psc_nx = tick ? '0 : psc + PSC_W'(1);
    end else if (state == S_IDLE || state == S_DONE) begin
      psc_nx = '0;
    end

    en_nx = tick;
    if (tick && cnt_tc) ovf_nx = 1'b1;

    case (state)
      S_IDLE:  if (ev_ss) state_nx = S_RUN;
      S_RUN:   if (ev_ss) state_nx = S_PAUSE;
               else if (ev_lap) state_nx = S_LAP;
      S_LAP:   if (ev_ss) state_nx = S_PAUSE;
               else if (ev_lap) state_nx = S_RUN;
      S_PAUSE: if (ev_ss) state_nx = S_RUN;
      default: state_nx = state;
    endcase

    // Non-wrapping terminal count overrides any button event on the same edge
    if (tick && cnt_tc && (WRAP == 0)) begin
      en_nx    = 1'b0;
      state_nx = S_DONE;
      psc_nx   = '0;
    end

    if (ev_clr) begin
      state_nx = S_IDLE;
      psc_nx   = '0;
      en_nx    = 1'b0;
      clr_nx   = 1'b1;
      ovf_nx   = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= S_IDLE;
      psc           <= '0;
      ss_p0         <= 1'b1;
      clr_p0        <= 1'b1;
      lap_p0        <= 1'b1;
      cnt_en        <= 1'b0;
      cnt_clr       <= 1'b0;
      disp_latch_en <= 1'b1;
      running       <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      state         <= state_nx;
      psc           <= psc_nx;
      ss_p0         <= start_stop;
      clr_p0        <= clear;
      lap_p0        <= lap;
      cnt_en        <= en_nx;
      cnt_clr       <= clr_nx;
      disp_latch_en <= (state_nx != S_LAP);
      running       <= (state_nx == S_RUN) || (state_nx == S_LAP);
      ovf           <= ovf_nx;
    end
  end

endmodule

// File: tb/tb_ms_count_ctrl.sv
// Bench for ms_count_ctrl: directed scenarios plus random button traffic
// compared against a behavioural model, on a WRAP=1 and a WRAP=0 instance.
module tb_ms_count_ctrl;
  localparam int CLK_HZ  = 10_000;
  localparam int TICK_HZ = 1000;
  localparam int DIV     = CLK_HZ / TICK_HZ;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic start_stop = 1'b0, clear = 1'b0, lap = 1'b0, cnt_tc = 1'b0;
  logic en1, clr1, disp1, run1, ovf1;
  logic en0, clr0, disp0, run0, ovf0;
  int n_checks = 0;
  int n_pass   = 0;

  wire [4:0] o1 = {en1, clr1, disp1, run1, ovf1};
  wire [4:0] o0 = {en0, clr0, disp0, run0, ovf0};

  ms_count_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WRAP(1)) u_wrap (
    .CLK(CLK), .RST(RST), .start_stop(start_stop), .clear(clear), .lap(lap),
    .cnt_tc(cnt_tc), .cnt_en(en1), .cnt_clr(clr1), .disp_latch_en(disp1),
    .running(run1), .ovf(ovf1));

  ms_count_ctrl #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .WRAP(0)) u_stop (
    .CLK(CLK), .RST(RST), .start_stop(start_stop), .clear(clear), .lap(lap),
    .cnt_tc(cnt_tc), .cnt_en(en0), .cnt_clr(clr0), .disp_latch_en(disp0),
    .running(run0), .ovf(ovf0));

  always #5 CLK = ~CLK;

  // Behavioural model: flags for the mode plus a count of running cycles since clear
  typedef struct packed {
    logic        run;
    logic        frz;
    logic        pau;
    logic        done;
    logic        ovf;
    logic        en;
    logic        clr;
    logic        pss;
    logic        pcl;
    logic        plp;
    logic [31:0] rc;
  } mdl_t;

  mdl_t m1, m0;

  function automatic mdl_t mreset();
    mdl_t r;
    r = '0;
    r.pss = 1'b1; r.pcl = 1'b1; r.plp = 1'b1;
    return r;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input logic ss, input logic cl,
                                 input logic lp, input logic tc, input int wrap);
    mdl_t n;
    logic e_ss, e_cl, e_lp, tk;
    n    = m;
    e_ss = ss & ~m.pss;
    e_cl = cl & ~m.pcl;
    e_lp = lp & ~m.plp;
    n.pss = ss; n.pcl = cl; n.plp = lp;
    tk = m.run && (((m.rc + 1) % DIV) == 0);
    n.en = 1'b0; n.clr = 1'b0;
    if (e_cl) begin
      n.run = 0; n.frz = 0; n.pau = 0; n.done = 0; n.ovf = 0; n.rc = 0; n.clr = 1;
    end else begin
      if (m.run) n.rc = m.rc + 1;
      n.en = tk;
      if (tk && tc) n.ovf = 1'b1;
      if (tk && tc && wrap == 0) begin
        n.en = 0; n.done = 1; n.run = 0; n.frz = 0; n.rc = 0;
      end else if (e_ss) begin
        if (m.run) begin n.run = 0; n.frz = 0; n.pau = 1; end
        else if (m.pau) begin n.run = 1; n.pau = 0; end
        else if (!m.done) n.run = 1;
      end else if (e_lp && m.run) begin
        n.frz = ~m.frz;
      end
    end
    return n;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m1 <= mreset();
      m0 <= mreset();
    end else begin
      m1 <= mstep(m1, start_stop, clear, lap, cnt_tc, 1);
      m0 <= mstep(m0, start_stop, clear, lap, cnt_tc, 0);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    start_stop = 0; clear = 0; lap = 0; cnt_tc = 0;
    RST = 1;
    tick(); tick();
    RST = 0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (o1 !== 5'b00100) $display("FAIL reset_wrap got=%b exp=00100", o1); else n_pass++;
    n_checks++;
    if (o0 !== 5'b00100) $display("FAIL reset_stop got=%b exp=00100", o0); else n_pass++;
  endtask

  task automatic test_start_ticks();
    logic [4:0] exp;
    do_reset();
    start_stop = 1; tick();
    n_checks++;
    if (o1 !== 5'b00110) $display("FAIL start_edge got=%b exp=00110", o1); else n_pass++;
    start_stop = 0;
    for (int k = 1; k <= 35; k++) begin
      tick();
      exp = {(k % 10 == 0), 1'b0, 1'b1, 1'b1, 1'b0};
      n_checks++;
      if (o1 !== exp) $display("FAIL start_ticks k=%0d got=%b exp=%b", k, o1, exp); else n_pass++;
    end
  endtask

  task automatic test_pause();
    logic [4:0] exp;
    do_reset();
    start_stop = 1; tick(); start_stop = 0;
    for (int k = 1; k <= 22; k++) begin
      tick();
      exp = {(k % 10 == 0), 1'b0, 1'b1, 1'b1, 1'b0};
      n_checks++;
      if (o1 !== exp) $display("FAIL pre_pause k=%0d got=%b exp=%b", k, o1, exp); else n_pass++;
    end
    start_stop = 1; tick(); start_stop = 0;
    n_checks++;
    if (o1 !== 5'b00100) $display("FAIL pause_edge got=%b exp=00100", o1); else n_pass++;
    for (int k = 1; k <= 40; k++) begin
      tick();
      n_checks++;
      if (o1 !== 5'b00100) $display("FAIL paused k=%0d got=%b exp=00100", k, o1); else n_pass++;
    end
    start_stop = 1; tick(); start_stop = 0;
    n_checks++;
    if (o1 !== 5'b00110) $display("FAIL resume_edge got=%b exp=00110", o1); else n_pass++;
    for (int k = 1; k <= 7; k++) begin
      tick();
      exp = {(k == 7), 1'b0, 1'b1, 1'b1, 1'b0};
      n_checks++;
      if (o1 !== exp) $display("FAIL resume k=%0d got=%b exp=%b", k, o1, exp); else n_pass++;
    end
  endtask

  task automatic test_lap();
    logic [4:0] exp;
    do_reset();
    start_stop = 1; tick(); start_stop = 0;
    repeat (5) tick();
    lap = 1; tick(); lap = 0;
    n_checks++;
    if (o1 !== 5'b00010) $display("FAIL lap_freeze got=%b exp=00010", o1); else n_pass++;
    for (int k = 1; k <= 30; k++) begin
      tick();
      exp = {((k + 6) % 10 == 0), 1'b0, 1'b0, 1'b1, 1'b0};
      n_checks++;
      if (o1 !== exp) $display("FAIL lap_ticks k=%0d got=%b exp=%b", k, o1, exp); else n_pass++;
    end
    lap = 1; tick(); lap = 0;
    n_checks++;
    if (o1 !== 5'b00110) $display("FAIL lap_release got=%b exp=00110", o1); else n_pass++;
  endtask

  task automatic test_clear_priority();
    do_reset();
    start_stop = 1; tick(); start_stop = 0;
    repeat (9) tick();
    cnt_tc = 1; tick(); cnt_tc = 0;
    n_checks++;
    if (o1 !== 5'b10111) $display("FAIL tc_wrap got=%b exp=10111", o1); else n_pass++;
    repeat (3) tick();
    clear = 1; start_stop = 1; lap = 1; tick();
    n_checks++;
    if (o1 !== 5'b01100) $display("FAIL clr_prio_wrap got=%b exp=01100", o1); else n_pass++;
    n_checks++;
    if (o0 !== 5'b01100) $display("FAIL clr_prio_stop got=%b exp=01100", o0); else n_pass++;
    clear = 0; start_stop = 0; lap = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      n_checks++;
      if (o1 !== 5'b00100) $display("FAIL idle_after_clr k=%0d got=%b exp=00100", k, o1); else n_pass++;
    end
  endtask

  task automatic test_wrap_modes();
    do_reset();
    start_stop = 1; tick(); start_stop = 0;
    repeat (9) tick();
    cnt_tc = 1; tick(); cnt_tc = 0;
    n_checks++;
    if (o1 !== 5'b10111) $display("FAIL wrap1_tc got=%b exp=10111", o1); else n_pass++;
    n_checks++;
    if (o0 !== 5'b00101) $display("FAIL wrap0_done got=%b exp=00101", o0); else n_pass++;
    start_stop = 1; tick(); start_stop = 0;
    for (int k = 0; k <= 20; k++) begin
      n_checks++;
      if (o0 !== 5'b00101) $display("FAIL done_hold k=%0d got=%b exp=00101", k, o0); else n_pass++;
      tick();
    end
    clear = 1; tick(); clear = 0;
    n_checks++;
    if (o0 !== 5'b01100) $display("FAIL done_clear got=%b exp=01100", o0); else n_pass++;
    tick();
    start_stop = 1; tick(); start_stop = 0;
    n_checks++;
    if (o0 !== 5'b00110) $display("FAIL idle_restart got=%b exp=00110", o0); else n_pass++;
  endtask

  task automatic test_reset_hold();
    start_stop = 1; clear = 0; lap = 0; cnt_tc = 0;
    RST = 1; tick(); tick(); RST = 0;
    for (int k = 1; k <= 50; k++) begin
      tick();
      n_checks++;
      if (o1 !== 5'b00100) $display("FAIL held_ss k=%0d got=%b exp=00100", k, o1); else n_pass++;
    end
    start_stop = 0; tick();
    start_stop = 1; tick(); start_stop = 0;
    n_checks++;
    if (o1 !== 5'b00110) $display("FAIL post_hold_start got=%b exp=00110", o1); else n_pass++;
    repeat (3) tick();
    lap = 1; tick(); lap = 0;
    repeat (2) tick();
    #2 RST = 1;
    #1;
    n_checks++;
    if (o1 !== 5'b00100) $display("FAIL async_rst_wrap got=%b exp=00100", o1); else n_pass++;
    n_checks++;
    if (o0 !== 5'b00100) $display("FAIL async_rst_stop got=%b exp=00100", o0); else n_pass++;
    tick();
    RST = 0;
    tick();
  endtask

  task automatic test_random();
    logic [4:0] e1, e0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) start_stop = ~start_stop;
      if ($urandom_range(0, 9) == 0) lap = ~lap;
      if ($urandom_range(0, 29) == 0) clear = ~clear;
      cnt_tc = ($urandom_range(0, 3) == 0);
      tick();
      e1 = {m1.en, m1.clr, ~m1.frz, m1.run, m1.ovf};
      e0 = {m0.en, m0.clr, ~m0.frz, m0.run, m0.ovf};
      n_checks++;
      if (o1 !== e1) $display("FAIL rand_wrap c=%0d got=%b exp=%b", c, o1, e1); else n_pass++;
      n_checks++;
      if (o0 !== e0) $display("FAIL rand_stop c=%0d got=%b exp=%b", c, o0, e0); else n_pass++;
      n_checks++;
      if ((en1 & clr1) !== 1'b0 || (en0 & clr0) !== 1'b0)
        $display("FAIL en_clr_excl c=%0d got=%b%b%b%b exp=no_overlap", c, en1, clr1, en0, clr0);
      else n_pass++;
    end
    start_stop = 0; clear = 0; lap = 0; cnt_tc = 0;
  endtask

  initial begin
    test_reset();
    test_start_ticks();
    test_pause();
    test_lap();
    test_clear_priority();
    test_wrap_modes();
    test_reset_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
